atmega_pcint: RTL and testbench
===============================

# atmega_pcint

Pin-change interrupt controller for one 8-bit I/O port group. It sits directly downstream of the port's pins, on the same io_i bundle that feeds the PIO block. It synchronises the pins and detects any level change on masked pins. On such a change it sets a sticky flag and raises an interrupt request to the interrupt vector controller. It exposes PCICR, PCIFR, PCMSK and a change-capture register on the I/O bus.

## Interface
Parameters:
- BUS_ADDR_DATA_LEN, 8, I/O address width
- PORT_WIDTH, 8, number of pins in the group (1..8)
- PCICR_ADDR, 'h68, control register address
- PCIFR_ADDR, 'h3B, flag register address
- PCMSK_ADDR, 'h6B, per-pin mask register address
- PCCAP_ADDR, 'h6C, change-capture register address (read-only)
- GROUP_BIT, 0, bit index of this group's PCIE in PCICR and PCIF in PCIFR

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-low
- addr_i  in  BUS_ADDR_DATA_LEN  I/O address
- wr_i  in  1  write strobe, one cycle
- rd_i  in  1  read strobe
- bus_i  in  8  write data
- bus_o  out  8  read data, combinational
- io_i  in  PORT_WIDTH  raw pin levels (asynchronous)
- int_ack_i  in  1  vector-taken pulse from interrupt controller
- irq_o  out  1  interrupt request, registered

## Operation
- Registers, all reset to 0:
  - PCIE: a single bit, located at PCICR[GROUP_BIT].
  - PCIF: a single bit, located at PCIFR[GROUP_BIT].
  - PCMSK: PORT_WIDTH bits.
  - PCCAP: PORT_WIDTH bits.
- Register access:
  - Writes decode on the full addr_i.
  - Other bits of PCICR/PCIFR read as 0 and ignore writes.
  - PCCAP ignores writes.
- Pin sampling:
  - io_i enters the input stage; its output is `s`.
  - A `last` register holds the previous `s` and updates every cycle, regardless of PCMSK.
- Priming:
  - A `primed` bit is 0 after reset.
  - On the first cycle out of reset, `last` <= `s` with no detection, and `primed` <= 1.
  - This prevents a spurious change when a pin idles high.
- Change detection: chg = (s ^ last) & PCMSK & {PORT_WIDTH{primed}}.
- Flag set: if chg != 0, then PCIF <= 1 and PCCAP <= PCCAP | chg.
- Flag clear:
  - PCIF clears on a write of 1 to PCIFR[GROUP_BIT], or on int_ack_i.
  - PCCAP clears to 0 on the same conditions.
  - Writing 0 to the bit has no effect.
- Set-over-clear priority: if chg != 0 in the same cycle as a clear, PCIF stays 1 and PCCAP <= chg (old bits dropped, new bits kept).
- Interrupt request:
  - irq_o <= PCIF_next & PCIE_next.
  - Clearing PCIE drops irq_o on the next edge; PCIF is retained.
  - Setting PCIE while PCIF=1 raises irq_o on the next edge.
- Mask changes: a PCMSK write takes effect for the detection on the following cycle. A pin unmasked while toggling does not generate a retroactive flag.
- Read path: bus_o = selected register when rd_i && rst_i; otherwise 0.

## Timing
- Reset: while rst_i=0 at a clock edge, all registers go to 0 and irq_o goes to 0. bus_o is 0 while rst_i=0.
- Latency (with sync): pin change stable before edge E0 → PCIF=1 and irq_o=1 after edge E2.
  - PCCAP becomes readable in the same cycle as PCIF.
- Clear latency: int_ack_i or a write-1-clear at edge E → PCIF=0 and irq_o=0 after E, unless a change is detected in the same cycle.
- Glitches: a pulse shorter than one clock may be missed. A level held at least 2 cycles is always detected, once per transition.
- Multiple changes while PCIF=1: the flag stays 1 and PCCAP accumulates. No extra request pulse is generated; irq_o is level.
- Reset mid-operation: pending flags are lost and `primed` is re-armed.

## Configuration
- PCINT_SYNC_EN defined: the input stage is a two-flop synchroniser. Latency is E0 → E2 as above.
- PCINT_SYNC_EN undefined: the input stage is a single register. Latency is E0 → E1.
  - Use this only when io_i is already synchronous to clk_i.
  - All other behaviour is identical.

## Test plan
- Reset primes without a spurious flag: hold io_i=8'hFF through reset, release rst_i, run 5 cycles → PCIFR=0, irq_o=0.
- Single-pin change with sync: PCMSK=8'h04, PCIE=1, toggle io_i[2] 0→1 before edge E0 → irq_o=1 after E2, PCCAP=8'h04. Then pulse int_ack_i → irq_o=0 and PCCAP=0 next cycle.
- Masked pin ignored: PCMSK=8'h01, toggle io_i[7] 4 times with 3-cycle spacing → PCIF=0, PCCAP=0.
- Set-over-clear: PCIF=1 with PCCAP=8'h01; write 8'h01 to PCIFR in the same cycle a change is detected on pin 3 → PCIF stays 1, PCCAP=8'h08.
- Enable gating: PCIE=0, change on masked pin 0 → PCIF=1, irq_o=0. Write PCICR=1 → irq_o=1 next edge. Write PCICR=0 → irq_o=0, PCIF remains 1.
- Without PCINT_SYNC_EN: the same stimulus as the single-pin change test gives irq_o=1 after E1.

Source files
------------

// File: rtl/atmega_pcint.sv
// atmega_pcint: pin-change interrupt controller for one 8-bit port group.
// Define PCINT_SYNC_EN for a two-flop synchroniser on io_i.
module atmega_pcint #(
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter int PORT_WIDTH = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PCICR_ADDR =
    BUS_ADDR_DATA_LEN'('h68),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PCIFR_ADDR =
    BUS_ADDR_DATA_LEN'('h3B),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PCMSK_ADDR =
    BUS_ADDR_DATA_LEN'('h6B),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PCCAP_ADDR =
    BUS_ADDR_DATA_LEN'('h6C),
  parameter int GROUP_BIT = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
  input  logic                         wr_i,
  input  logic                         rd_i,
  input  logic [7:0]                   bus_i,
  output logic [7:0]                   bus_o,
  input  logic [PORT_WIDTH-1:0]        io_i,
  input  logic                         int_ack_i,
  output logic                         irq_o
);

  logic [PORT_WIDTH-1:0] s;
  logic [PORT_WIDTH-1:0] last;
  logic [PORT_WIDTH-1:0] pcmsk;
  logic [PORT_WIDTH-1:0] pccap;
  logic [PORT_WIDTH-1:0] pccap_n;
  logic [PORT_WIDTH-1:0] chg;
  logic                  primed;
  logic                  pcie;
  logic                  pcie_n;
  logic                  pcif;
  logic                  pcif_n;
  logic                  wr_pcicr;
  logic                  wr_pcifr;
  logic                  wr_pcmsk;
  logic                  clr;

  // Input stage runs through reset so `last` primes to a settled level.
`ifdef PCINT_SYNC_EN
  logic [PORT_WIDTH-1:0] meta;

  always_ff @(posedge clk_i) begin
    meta <= io_i;
    s    <= meta;
  end
`else
  always_ff @(posedge clk_i) begin
    s <= io_i;
  end
`endif

  assign wr_pcicr = wr_i && (addr_i == PCICR_ADDR);
  assign wr_pcifr = wr_i && (addr_i == PCIFR_ADDR);
  assign wr_pcmsk = wr_i && (addr_i == PCMSK_ADDR);

  assign clr = int_ack_i || (wr_pcifr && bus_i[GROUP_BIT]);
  assign chg = (s ^ last) & pcmsk & {PORT_WIDTH{primed}};

  assign pcif_n  = (|chg) || (pcif && !clr);
  assign pccap_n = (clr ? '0 : pccap) | chg;
  assign pcie_n  = wr_pcicr ? bus_i[GROUP_BIT] : pcie;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      last   <= '0;
      primed <= 1'b0;
      pcie   <= 1'b0;
      pcif   <= 1'b0;
      pcmsk  <= '0;
      pccap  <= '0;
      irq_o  <= 1'b0;
    end else begin
      last   <= s;
      primed <= 1'b1;
      pcie   <= pcie_n;
      pcif   <= pcif_n;
      pccap  <= pccap_n;
      irq_o  <= pcif_n && pcie_n;
      if (wr_pcmsk) begin
        pcmsk <= bus_i[PORT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    bus_o = '0;
    if (rd_i && rst_i) begin
      unique case (1'b1)
        addr_i == PCICR_ADDR: bus_o[GROUP_BIT] = pcie;
        addr_i == PCIFR_ADDR: bus_o[GROUP_BIT] = pcif;
        addr_i == PCMSK_ADDR: bus_o[PORT_WIDTH-1:0] = pcmsk;
        addr_i == PCCAP_ADDR: bus_o[PORT_WIDTH-1:0] = pccap;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atmega_pcint.sv
// tb_atmega_pcint: directed and random checks of atmega_pcint
// against a pin-history reference model.
module tb_atmega_pcint;

`ifdef PCINT_SYNC_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif

  localparam logic [7:0] PCICR_A = 8'h68;
  localparam logic [7:0] PCIFR_A = 8'h3B;
  localparam logic [7:0] PCMSK_A = 8'h6B;
  localparam logic [7:0] PCCAP_A = 8'h6C;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] addr_i;
  logic       wr_i;
  logic       rd_i;
  logic [7:0] bus_i;
  logic [7:0] bus_o;
  logic [7:0] io_i;
  logic       int_ack_i;
  logic       irq_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  atmega_pcint dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .wr_i     (wr_i),
    .rd_i     (rd_i),
    .bus_i    (bus_i),
    .bus_o    (bus_o),
    .io_i     (io_i),
    .int_ack_i(int_ack_i),
    .irq_o    (irq_o)
  );

  initial forever #5 clk = ~clk;

  // Reference model: pin levels seen at past edges.
  logic [7:0] ph [0:2] = '{8'h0, 8'h0, 8'h0};
  logic       m_rprev = 1'b0;
  logic       m_ie = 1'b0;
  logic       m_if = 1'b0;
  logic [7:0] m_msk = 8'h0;
  logic [7:0] m_cap = 8'h0;
  logic       m_irq = 1'b0;
  logic [7:0] m_chg;
  logic       m_clr;
  logic       m_if_n;
  logic       m_ie_n;
  logic [7:0] m_cap_n;

  always_comb begin
    m_chg = 8'h0;
    if (rst_i && m_rprev) m_chg = (ph[D] ^ ph[D+1]) & m_msk;
    m_clr = int_ack_i ||
            (wr_i && addr_i == PCIFR_A && bus_i[0]);
    m_if_n = m_if;
    m_cap_n = m_cap;
    if (m_chg != 8'h0 && m_clr) begin
      m_if_n = 1'b1;
      m_cap_n = m_chg;
    end else if (m_chg != 8'h0) begin
      m_if_n = 1'b1;
      m_cap_n = m_cap | m_chg;
    end else if (m_clr) begin
      m_if_n = 1'b0;
      m_cap_n = 8'h0;
    end
    m_ie_n = m_ie;
    if (wr_i && addr_i == PCICR_A) m_ie_n = bus_i[0];
  end

  always @(posedge clk) begin
    if (!rst_i) begin
      m_ie  <= 1'b0;
      m_if  <= 1'b0;
      m_cap <= 8'h0;
      m_msk <= 8'h0;
      m_irq <= 1'b0;
    end else begin
      m_ie  <= m_ie_n;
      m_if  <= m_if_n;
      m_cap <= m_cap_n;
      m_irq <= m_if_n & m_ie_n;
      if (wr_i && addr_i == PCMSK_A) m_msk <= bus_i;
    end
    m_rprev <= rst_i;
    ph[0] <= io_i;
    ph[1] <= ph[0];
    ph[2] <= ph[1];
  end

  function automatic logic [7:0] m_rd();
    if (!rd_i || !rst_i) return 8'h0;
    case (addr_i)
      PCICR_A: return {7'b0, m_ie};
      PCIFR_A: return {7'b0, m_if};
      PCMSK_A: return m_msk;
      PCCAP_A: return m_cap;
      default: return 8'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("model_irq", {7'b0, irq_o}, {7'b0, m_irq});
      chk("model_bus", bus_o, m_rd());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    addr_i = a;
    bus_i = d;
    wr_i = 1'b1;
    @(negedge clk);
    wr_i = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a,
                        input logic [7:0] e);
    addr_i = a;
    rd_i = 1'b1;
    #1;
    chk(nm, bus_o, e);
    @(negedge clk);
    rd_i = 1'b0;
  endtask

  logic [7:0] addrs [0:4] = '{8'h68, 8'h3B, 8'h6B, 8'h6C, 8'h00};

  initial begin
    rst_i = 1'b0;
    addr_i = 8'h0;
    wr_i = 1'b0;
    rd_i = 1'b0;
    bus_i = 8'h0;
    io_i = 8'hFF;
    int_ack_i = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_irq", {7'b0, irq_o}, 8'h0);
    idle(3);
    rst_i = 1'b1;
    idle(5);
    rd_chk("prime_pcifr", PCIFR_A, 8'h00);
    chk("prime_irq", {7'b0, irq_o}, 8'h0);

    io_i = 8'h00;
    idle(4);
    wr_reg(PCMSK_A, 8'h04);
    wr_reg(PCICR_A, 8'h01);
    io_i[2] = 1'b1;
    @(posedge clk); #1;
    chk("lat_e0", {7'b0, irq_o}, 8'h0);
    @(posedge clk); #1;
    chk("lat_e1", {7'b0, irq_o}, (D == 0) ? 8'h1 : 8'h0);
    @(posedge clk); #1;
    chk("lat_e2", {7'b0, irq_o}, 8'h1);
    @(negedge clk);
    rd_chk("single_cap", PCCAP_A, 8'h04);
    int_ack_i = 1'b1;
    @(posedge clk); #1;
    chk("ack_irq", {7'b0, irq_o}, 8'h0);
    @(negedge clk);
    int_ack_i = 1'b0;
    rd_chk("ack_cap", PCCAP_A, 8'h00);
    rd_chk("ack_pcifr", PCIFR_A, 8'h00);

    wr_reg(PCMSK_A, 8'h01);
    for (int i = 0; i < 4; i++) begin
      io_i[7] = ~io_i[7];
      idle(3);
    end
    rd_chk("masked_pcifr", PCIFR_A, 8'h00);
    rd_chk("masked_cap", PCCAP_A, 8'h00);

    wr_reg(PCMSK_A, 8'h09);
    io_i[0] = 1'b1;
    idle(4);
    rd_chk("soc_pre_cap", PCCAP_A, 8'h01);
    io_i[3] = 1'b1;
    repeat (D + 1) @(negedge clk);
    wr_reg(PCIFR_A, 8'h01);
    rd_chk("soc_cap", PCCAP_A, 8'h08);
    rd_chk("soc_pcifr", PCIFR_A, 8'h01);
    chk("soc_irq", {7'b0, irq_o}, 8'h1);
    wr_reg(PCIFR_A, 8'h01);
    rd_chk("w1c_pcifr", PCIFR_A, 8'h00);

    wr_reg(PCICR_A, 8'h00);
    io_i[0] = 1'b0;
    idle(4);
    rd_chk("gate_pcifr", PCIFR_A, 8'h01);
    chk("gate_irq0", {7'b0, irq_o}, 8'h0);
    wr_reg(PCICR_A, 8'h01);
    chk("gate_irq1", {7'b0, irq_o}, 8'h1);
    wr_reg(PCICR_A, 8'h00);
    chk("gate_irq_off", {7'b0, irq_o}, 8'h0);
    rd_chk("gate_keep", PCIFR_A, 8'h01);
    wr_reg(PCIFR_A, 8'h00);
    rd_chk("w0_noeffect", PCIFR_A, 8'h01);
    wr_reg(PCIFR_A, 8'h01);

    wr_reg(PCCAP_A, 8'hFF);
    rd_chk("cap_ro", PCCAP_A, 8'h00);
    wr_reg(PCICR_A, 8'hFF);
    rd_chk("pcicr_bits", PCICR_A, 8'h01);

    io_i[0] = 1'b1;
    idle(4);
    rst_i = 1'b0;
    idle(2);
    rd_chk("rst_bus0", PCIFR_A, 8'h00);
    rst_i = 1'b1;
    idle(3);
    rd_chk("rst_pcifr", PCIFR_A, 8'h00);
    rd_chk("rst_pcmsk", PCMSK_A, 8'h00);
    chk("rst_irq2", {7'b0, irq_o}, 8'h0);

    for (int n = 0; n < 3000; n++) begin
      rst_i = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) io_i = io_i ^ 8'($urandom);
      addr_i = addrs[$urandom_range(0, 4)];
      bus_i = 8'($urandom);
      wr_i = ($urandom_range(0, 4) == 0);
      rd_i = $urandom_range(0, 1) == 1;
      int_ack_i = ($urandom_range(0, 11) == 0);
      @(negedge clk);
    end
    wr_i = 1'b0;
    rd_i = 1'b0;
    int_ack_i = 1'b0;
    rst_i = 1'b1;
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
